// File: rtl/rot_seq_engine_if.sv
// Request/response bundle for rot_seq_engine: vector in, rotated vector out,
// each side with its own valid/ready pair plus a busy indication.
interface rot_seq_engine_if #(
    parameter int CORDIC_WIDTH = 22,
    parameter int N_ITER       = 16
);
    logic                           in_valid;
    logic                           in_ready;
    logic signed [CORDIC_WIDTH-1:0] x_in;
    logic signed [CORDIC_WIDTH-1:0] y_in;
    logic        [N_ITER-1:0]       micro_rot_in;
    logic signed [CORDIC_WIDTH-1:0] x_out;
    logic signed [CORDIC_WIDTH-1:0] y_out;
    logic                           out_valid;
    logic                           out_ready;
    logic                           busy;

    // Requester / consumer side
    modport master (
        output in_valid, x_in, y_in, micro_rot_in, out_ready,
        input  in_ready, x_out, y_out, out_valid, busy
    );

    // Engine side
    modport slave (
        input  in_valid, x_in, y_in, micro_rot_in, out_ready,
        output in_ready, x_out, y_out, out_valid, busy
    );
endinterface

// File: rtl/rot_seq_engine.sv
// Iterative CORDIC-style rotation engine. One micro-rotation per cycle with
// shift k; direction bit k of the latched word selects the rotation sense.
// Optional feature macro ROT_GAIN_COMP_EN adds a COMP state that scales the
// result once by ~0.6074 (one extra cycle of latency).
module rot_seq_engine #(
    parameter int CORDIC_WIDTH = 22,
    parameter int N_ITER       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    rot_seq_engine_if.slave       bus
);
    localparam int K_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;

`ifdef ROT_GAIN_COMP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, COMP = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic        [K_W-1:0]          r_k;
    logic        [N_ITER-1:0]       r_dir;
    logic signed [CORDIC_WIDTH-1:0] r_x;
    logic signed [CORDIC_WIDTH-1:0] r_y;
    logic signed [CORDIC_WIDTH-1:0] r_x_out;
    logic signed [CORDIC_WIDTH-1:0] r_y_out;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic                           r_busy;

    logic signed [CORDIC_WIDTH-1:0] w_x_sh;
    logic signed [CORDIC_WIDTH-1:0] w_y_sh;
    logic signed [CORDIC_WIDTH-1:0] w_x_nxt;
    logic signed [CORDIC_WIDTH-1:0] w_y_nxt;
    logic                           w_last;
    logic                           w_accept;

`ifdef ROT_GAIN_COMP_EN
    // Constant-gain compensation: (v>>>1)+(v>>>3)-(v>>>6)-(v>>>9), wrapping
    function automatic logic signed [CORDIC_WIDTH-1:0] gain_comp(
        input logic signed [CORDIC_WIDTH-1:0] v
    );
        gain_comp = (v >>> 4'd1) + (v >>> 4'd3) - (v >>> 4'd6) - (v >>> 4'd9);
    endfunction
`endif

    assign w_last   = (r_k == K_W'(N_ITER - 1));
    assign w_accept = (r_state == IDLE) && bus.in_valid;

    // One micro-rotation from the pre-iteration x/y; direction taken from bit 0
    // of the shifting direction register (bit k of the original word).
    always_comb begin
        w_x_sh  = r_x >>> r_k;
        w_y_sh  = r_y >>> r_k;
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (r_dir[0]) begin
            w_x_nxt = r_x - w_y_sh;
            w_y_nxt = r_y + w_x_sh;
        end else begin
            w_x_nxt = r_x + w_y_sh;
            w_y_nxt = r_y - w_x_sh;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) w_state_nxt = ROTATE;
                else              w_state_nxt = IDLE;
            end
            ROTATE: begin
                if (w_last) begin
`ifdef ROT_GAIN_COMP_EN
                    w_state_nxt = COMP;
`else
                    w_state_nxt = DONE;
`endif
                end else begin
                    w_state_nxt = ROTATE;
                end
            end
`ifdef ROT_GAIN_COMP_EN
            COMP: w_state_nxt = DONE;
`endif
            DONE: begin
                if (bus.out_ready) w_state_nxt = IDLE;
                else               w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Handshake/status outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    // Working datapath and result registers; results load only on DONE entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k     <= '0;
            r_dir   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x   <= bus.x_in;
                        r_y   <= bus.y_in;
                        r_dir <= bus.micro_rot_in;
                        r_k   <= '0;
                    end
                end
                ROTATE: begin
                    r_x   <= w_x_nxt;
                    r_y   <= w_y_nxt;
                    r_dir <= r_dir >> 1;
                    r_k   <= r_k + K_W'(1);
`ifndef ROT_GAIN_COMP_EN
                    if (w_last) begin
                        r_x_out <= w_x_nxt;
                        r_y_out <= w_y_nxt;
                    end
`endif
                end
`ifdef ROT_GAIN_COMP_EN
                COMP: begin
                    r_x_out <= gain_comp(r_x);
                    r_y_out <= gain_comp(r_y);
                end
`endif
                DONE: begin
                    r_k <= r_k;
                end
                default: begin
                    r_k <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.x_out     = r_x_out;
    assign bus.y_out     = r_y_out;

endmodule
